// File: rtl/ysyx_24080006_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e   : controller states
//   F3_*          : funct3 encodings for access size / signedness
//   AXI_RESP_OKAY : the only AXI response treated as success
package ysyx_24080006_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24080006_lsu_fmt.sv
// Combinational data formatting for 32-bit loads and stores.
// Ports:
//   funct3  in  3   access size / sign
//   addr_lo in  2   byte lane offset (address bits [1:0])
//   sdata   in  32  raw store data (rs2)
//   rdata   in  32  raw bus read data
//   wdata   out 32  store data replicated onto the addressed lanes
//   wstrb   out 4   byte strobes for the store
//   ldata   out 32  load data shifted down and sign/zero extended
module ysyx_24080006_lsu_fmt
  import ysyx_24080006_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  always_comb begin
    // Store: replicate the narrow datum over every lane so the strobe alone
    // selects the destination byte(s).
    wstrb = 4'b1111;
    wdata = sdata;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{sdata[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{sdata[15:0]}};
      end
      default: ;
    endcase

    // Load: bring the addressed lane down to bit 0, then extend.
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ldata = {24'd0, shifted[7:0]};
      F3_HU:   ldata = {16'd0, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_24080006_lsu.sv
// Load/store stage between execute and write-back.
// Accepts one op per in_valid/in_ready handshake, performs at most one
// AXI4-Lite beat for loads/stores, and presents the result plus the captured
// sideband fields on out_valid/out_ready.
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   in_valid/in_ready            upstream handshake
//   in_alu_res/in_sdata/in_funct3/in_load/in_store  op payload
//   in_pc..in_ecall              sideband, returned on out_* unchanged
//   out_valid/out_ready          downstream handshake
//   out_wdata/out_fault          load data (or alu result) and bus error flag
//   m_ar*/m_r*/m_aw*/m_w*/m_b*   AXI4-Lite master channels
module ysyx_24080006_lsu
  import ysyx_24080006_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RD_W  = 4,
  parameter int CSR_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_alu_res,
  input  logic [XLEN-1:0]  in_sdata,
  input  logic [2:0]       in_funct3,
  input  logic             in_load,
  input  logic             in_store,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_dnpc,
  input  logic [RD_W-1:0]  in_rd_addr,
  input  logic             in_wb,
  input  logic             in_jump,
  input  logic             in_branch,
  input  logic [CSR_W-1:0] in_csr_addr,
  input  logic             in_csr_we,
  input  logic [XLEN-1:0]  in_csr_wdata,
  input  logic             in_ecall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_wdata,
  output logic             out_fault,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_dnpc,
  output logic [RD_W-1:0]  out_rd_addr,
  output logic             out_wb,
  output logic             out_jump,
  output logic             out_branch,
  output logic [CSR_W-1:0] out_csr_addr,
  output logic             out_csr_we,
  output logic [XLEN-1:0]  out_csr_wdata,
  output logic             out_ecall,
  output logic             m_arvalid,
  input  logic             m_arready,
  output logic [XLEN-1:0]  m_araddr,
  input  logic             m_rvalid,
  output logic             m_rready,
  input  logic [XLEN-1:0]  m_rdata,
  input  logic [1:0]       m_rresp,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic [XLEN-1:0]  m_awaddr,
  output logic             m_wvalid,
  input  logic             m_wready,
  output logic [XLEN-1:0]  m_wdata,
  output logic [3:0]       m_wstrb,
  input  logic             m_bvalid,
  output logic             m_bready,
  input  logic [1:0]       m_bresp
);

  lsu_state_e state_reg, state_next;

  logic [XLEN-1:0]  alu_res_reg, sdata_reg, wdata_reg;
  logic [2:0]       funct3_reg;
  logic             fault_reg;
  logic             aw_done_reg, w_done_reg;
  logic [XLEN-1:0]  pc_reg, dnpc_reg, csr_wdata_reg;
  logic [RD_W-1:0]  rd_addr_reg;
  logic [CSR_W-1:0] csr_addr_reg;
  logic             wb_reg, jump_reg, branch_reg, csr_we_reg, ecall_reg;
  logic [XLEN-1:0]  ldata;

  // Addresses and write data come straight from capture registers, so they
  // cannot move while a valid is outstanding.
  ysyx_24080006_lsu_fmt u_fmt (
    .funct3  (funct3_reg),
    .addr_lo (alu_res_reg[1:0]),
    .sdata   (sdata_reg),
    .rdata   (m_rdata),
    .wdata   (m_wdata),
    .wstrb   (m_wstrb),
    .ldata   (ldata)
  );

  assign m_araddr = alu_res_reg;
  assign m_awaddr = alu_res_reg;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = in_load ? RD_ADDR : (in_store ? WR_ADDR : DONE);
      end
      RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) state_next = DONE;
      end
      WR_ADDR: begin
        // AW and W retire independently; leave once both have been seen,
        // counting a handshake that completes in this very cycle.
        m_awvalid = !aw_done_reg;
        m_wvalid  = !w_done_reg;
        if ((aw_done_reg || m_awready) && (w_done_reg || m_wready))
          state_next = WR_RESP;
      end
      WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      alu_res_reg   <= '0;
      sdata_reg     <= '0;
      wdata_reg     <= '0;
      funct3_reg    <= '0;
      fault_reg     <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      pc_reg        <= '0;
      dnpc_reg      <= '0;
      csr_wdata_reg <= '0;
      rd_addr_reg   <= '0;
      csr_addr_reg  <= '0;
      wb_reg        <= 1'b0;
      jump_reg      <= 1'b0;
      branch_reg    <= 1'b0;
      csr_we_reg    <= 1'b0;
      ecall_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          alu_res_reg   <= in_alu_res;
          sdata_reg     <= in_sdata;
          wdata_reg     <= in_alu_res;
          funct3_reg    <= in_funct3;
          fault_reg     <= 1'b0;
          aw_done_reg   <= 1'b0;
          w_done_reg    <= 1'b0;
          pc_reg        <= in_pc;
          dnpc_reg      <= in_dnpc;
          csr_wdata_reg <= in_csr_wdata;
          rd_addr_reg   <= in_rd_addr;
          csr_addr_reg  <= in_csr_addr;
          wb_reg        <= in_wb;
          jump_reg      <= in_jump;
          branch_reg    <= in_branch;
          csr_we_reg    <= in_csr_we;
          ecall_reg     <= in_ecall;
        end
        RD_DATA: if (m_rvalid) begin
          if (m_rresp != AXI_RESP_OKAY) begin
            // A failed load must not write back garbage into rd.
            fault_reg <= 1'b1;
            wdata_reg <= '0;
            wb_reg    <= 1'b0;
          end else begin
            wdata_reg <= ldata;
          end
        end
        WR_ADDR: begin
          aw_done_reg <= aw_done_reg | m_awready;
          w_done_reg  <= w_done_reg | m_wready;
        end
        WR_RESP: if (m_bvalid && (m_bresp != AXI_RESP_OKAY)) begin
          fault_reg <= 1'b1;
          wdata_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_wdata     = wdata_reg;
  assign out_fault     = fault_reg;
  assign out_pc        = pc_reg;
  assign out_dnpc      = dnpc_reg;
  assign out_rd_addr   = rd_addr_reg;
  assign out_wb        = wb_reg;
  assign out_jump      = jump_reg;
  assign out_branch    = branch_reg;
  assign out_csr_addr  = csr_addr_reg;
  assign out_csr_we    = csr_we_reg;
  assign out_csr_wdata = csr_wdata_reg;
  assign out_ecall     = ecall_reg;

endmodule
